// File: rtl/chess_pkg.sv
// Shared chess encodings for the diagonal scan sequencer: piece codes,
// direction codes, FSM states and board geometry.
package chess_pkg;

  localparam int unsigned SQ_W    = 6;
  localparam int unsigned NUM_SQ  = 64;
  localparam int unsigned PIECE_W = 4;
  localparam int unsigned NUM_DIR = 4;
  localparam int unsigned BOARD_W = NUM_SQ * PIECE_W;

  typedef enum logic [2:0] {
    PC_EMPTY  = 3'b000,
    PC_PAWN   = 3'b001,
    PC_KNIGHT = 3'b010,
    PC_BISHOP = 3'b011,
    PC_ROOK   = 3'b100,
    PC_QUEEN  = 3'b101,
    PC_KING   = 3'b110
  } piece_kind_t;

  typedef struct packed {
    logic        colour;
    piece_kind_t kind;
  } piece_t;

  typedef enum logic [1:0] {
    DIR_UL = 2'd0,
    DIR_UR = 2'd1,
    DIR_DL = 2'd2,
    DIR_DR = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Up means towards row 0, left means towards column 0.
  function automatic logic dir_up(input dir_t d);
    return (d == DIR_UL) || (d == DIR_UR);
  endfunction

  function automatic logic dir_left(input dir_t d);
    return (d == DIR_UL) || (d == DIR_DL);
  endfunction

endpackage

// File: rtl/diag_step_calc.sv
// One diagonal step from {row,col} in a direction; off_board_c flags that the
// step would leave the board, in which case next_sq_c is meaningless.
module diag_step_calc
  import chess_pkg::*;
(
  input  logic [2:0]      row,
  input  logic [2:0]      col,
  input  dir_t            dir,
  output logic [SQ_W-1:0] next_sq_c,
  output logic            off_board_c
);

  logic       up;
  logic       left;
  logic [2:0] next_row;
  logic [2:0] next_col;

  always_comb begin
    up          = dir_up(dir);
    left        = dir_left(dir);
    off_board_c = (up ? (row == 3'd0) : (row == 3'd7)) ||
                  (left ? (col == 3'd0) : (col == 3'd7));
    next_row    = up ? (row - 3'd1) : (row + 3'd1);
    next_col    = left ? (col - 3'd1) : (col + 3'd1);
    next_sq_c   = {next_row, next_col};
  end

endmodule

// File: rtl/diag_scan_sequencer.sv
// Multi-cycle diagonal scanner: walks UL, UR, DL, DR from a latched origin one
// square per clock, reporting the first piece per direction and any attack.
module diag_scan_sequencer
  import chess_pkg::*;
#(
  parameter logic [NUM_DIR-1:0] DIR_MASK   = 4'b1111,
  parameter bit                 KING_CHECK = 1'b1
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BOARD_W-1:0]         bigBoard,
  input  logic [SQ_W-1:0]            currentPosition,
  input  logic                       my_colour,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_DIR-1:0]         hit_valid,
  output logic [NUM_DIR*SQ_W-1:0]    hit_pos,
  output logic [NUM_DIR*PIECE_W-1:0] hit_piece,
  output logic                       attacked
);

  state_t                          state_q, state_d;
  logic [NUM_SQ-1:0][PIECE_W-1:0]  board_q;
  logic [SQ_W-1:0]                 origin_q;
  logic [SQ_W-1:0]                 exam_q;
  logic                            colour_q;
  logic                            exam_ok_q;
  logic                            first_q;
  dir_t                            dir_q;
  logic [NUM_DIR-1:0][SQ_W-1:0]    pos_q;
  logic [NUM_DIR-1:0][PIECE_W-1:0] piece_q;

  dir_t            entry_dir_c;
  logic [SQ_W-1:0] step_sq_c, entry_sq_c;
  logic            step_off_c, entry_off_c;
  piece_t          exam_piece_c;
  logic            accept_c, cancel_c, load_c, hit_c, attack_c, advance_c, end_dir_c;

  assign exam_piece_c = piece_t'(board_q[exam_q]);
  assign entry_dir_c  = (state_q == ST_LOAD) ? DIR_UL : dir_t'(dir_q + 2'd1);
  assign hit_pos      = pos_q;
  assign hit_piece    = piece_q;

  // Next square along the current direction, used to continue an empty walk.
  diag_step_calc u_step (
    .row         (exam_q[5:3]),
    .col         (exam_q[2:0]),
    .dir         (dir_q),
    .next_sq_c   (step_sq_c),
    .off_board_c (step_off_c)
  );

  // First square of the direction about to be entered, taken from the origin.
  diag_step_calc u_entry (
    .row         (origin_q[5:3]),
    .col         (origin_q[2:0]),
    .dir         (entry_dir_c),
    .next_sq_c   (entry_sq_c),
    .off_board_c (entry_off_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    cancel_c  = 1'b0;
    load_c    = 1'b0;
    hit_c     = 1'b0;
    attack_c  = 1'b0;
    advance_c = 1'b0;
    end_dir_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          accept_c = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        state_d = ST_WALK;
      end
      ST_WALK: begin
        if (!exam_ok_q) begin
          end_dir_c = 1'b1;
        end else if (exam_piece_c.kind != PC_EMPTY) begin
          hit_c     = 1'b1;
          end_dir_c = 1'b1;
          attack_c  = (exam_piece_c.colour != colour_q) &&
                      ((exam_piece_c.kind == PC_BISHOP) || (exam_piece_c.kind == PC_QUEEN) ||
                       (KING_CHECK && (exam_piece_c.kind == PC_KING) && first_q));
        end else if (step_off_c) begin
          end_dir_c = 1'b1;
        end else begin
          advance_c = 1'b1;
        end
        if (end_dir_c && (dir_q == DIR_DR)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort discards an in-flight scan; a finished scan keeps its results.
    if (abort && ((state_q == ST_LOAD) || (state_q == ST_WALK))) begin
      state_d   = ST_IDLE;
      cancel_c  = 1'b1;
      load_c    = 1'b0;
      hit_c     = 1'b0;
      attack_c  = 1'b0;
      advance_c = 1'b0;
      end_dir_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q   <= '0;
      origin_q  <= '0;
      colour_q  <= 1'b0;
      dir_q     <= DIR_UL;
      exam_q    <= '0;
      exam_ok_q <= 1'b0;
      first_q   <= 1'b0;
      hit_valid <= '0;
      pos_q     <= '0;
      piece_q   <= '0;
      attacked  <= 1'b0;
    end else begin
      if (accept_c) begin
        board_q  <= bigBoard;
        origin_q <= currentPosition;
        colour_q <= my_colour;
      end
      if (accept_c || cancel_c) begin
        hit_valid <= '0;
        pos_q     <= '0;
        piece_q   <= '0;
        attacked  <= 1'b0;
      end
      // Entering a direction: a masked or edge-blocked one just burns a cycle.
      if (load_c || end_dir_c) begin
        dir_q     <= entry_dir_c;
        exam_q    <= entry_sq_c;
        exam_ok_q <= DIR_MASK[entry_dir_c] && !entry_off_c;
        first_q   <= 1'b1;
      end else if (advance_c) begin
        exam_q  <= step_sq_c;
        first_q <= 1'b0;
      end
      if (hit_c) begin
        hit_valid[dir_q] <= 1'b1;
        pos_q[dir_q]     <= exam_q;
        piece_q[dir_q]   <= exam_piece_c;
      end
      if (attack_c) attacked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_diag_scan_sequencer.sv
// Scoreboard bench for diag_scan_sequencer: a direct board-walk model predicts
// per-scan results and latency; a monitor checks them on every done pulse.
module tb_diag_scan_sequencer;

  logic         clk;
  logic         reset;
  logic         start;
  logic         abort;
  logic [255:0] bigBoard;
  logic [5:0]   currentPosition;
  logic         my_colour;
  logic         busy;
  logic         done;
  logic [3:0]   hit_valid;
  logic [23:0]  hit_pos;
  logic [15:0]  hit_piece;
  logic         attacked;

  diag_scan_sequencer #(.DIR_MASK(4'b1111), .KING_CHECK(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .bigBoard        (bigBoard),
    .currentPosition (currentPosition),
    .my_colour       (my_colour),
    .busy            (busy),
    .done            (done),
    .hit_valid       (hit_valid),
    .hit_pos         (hit_pos),
    .hit_piece       (hit_piece),
    .attacked        (attacked)
  );

  typedef struct {
    logic [3:0]  hv;
    logic [23:0] hp;
    logic [15:0] hpc;
    logic        atk;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_lat = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Walk each diagonal on the board grid; cost per direction is max(1, squares looked at).
  function automatic exp_t model(input logic [255:0] b, input logic [5:0] p, input logic c);
    exp_t       e;
    int         r, cc, dr, dc, n, cost, sq;
    logic [3:0] pc;
    logic       stop;
    e.hv = '0; e.hp = '0; e.hpc = '0; e.atk = 1'b0; e.start_cyc = 0;
    cost = 0;
    for (int d = 0; d < 4; d++) begin
      dr = (d >= 2) ? 1 : -1;
      dc = (d % 2 == 1) ? 1 : -1;
      r = int'(p[5:3]);
      cc = int'(p[2:0]);
      n = 0;
      stop = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (!stop) begin
          r += dr;
          cc += dc;
          if (r < 0 || r > 7 || cc < 0 || cc > 7) begin
            stop = 1'b1;
          end else begin
            n++;
            sq = r * 8 + cc;
            pc = b[sq*4 +: 4];
            if (pc[2:0] != 3'd0) begin
              e.hv[d] = 1'b1;
              e.hp[d*6 +: 6] = 6'(sq);
              e.hpc[d*4 +: 4] = pc;
              if (pc[3] != c && (pc[2:0] == 3'd3 || pc[2:0] == 3'd5 || (pc[2:0] == 3'd6 && n == 1)))
                e.atk = 1'b1;
              stop = 1'b1;
            end
          end
        end
      end
      cost += (n == 0) ? 1 : n;
    end
    e.lat = cost + 2;
    return e;
  endfunction

  function automatic logic [255:0] rand_board(input int density);
    logic [255:0] b;
    b = '0;
    for (int s = 0; s < 64; s++)
      if (int'($urandom_range(99)) < density)
        b[s*4 +: 4] = {1'($urandom), 3'($urandom_range(6, 1))};
    return b;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending scan (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        last_lat = cyc - mon_e.start_cyc + 1;
        check("sb_hit_valid", 32'(hit_valid), 32'(mon_e.hv));
        check("sb_hit_pos", 32'(hit_pos), 32'(mon_e.hp));
        check("sb_hit_piece", 32'(hit_piece), 32'(mon_e.hpc));
        check("sb_attacked", 32'(attacked), 32'(mon_e.atk));
        check("sb_latency", 32'(last_lat), 32'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; returns at a negedge once the scan has finished.
  task automatic do_scan(input logic [255:0] b, input logic [5:0] p, input logic c);
    exp_t e;
    int   t;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    e = model(b, p, c);
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    bigBoard = b;
    currentPosition = p;
    my_colour = c;
    @(negedge clk);
    start = 1'b0;
    bigBoard = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    currentPosition = 6'($urandom);
    my_colour = 1'($urandom);
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check("scan_timeout", 32'(busy), 32'd0);
  endtask

  logic [255:0] b;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bigBoard = '0; currentPosition = '0; my_colour = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit_valid", 32'(hit_valid), 32'd0);
    check("rst_hit_pos", 32'(hit_pos), 32'd0);
    check("rst_hit_piece", 32'(hit_piece), 32'd0);
    check("rst_attacked", 32'(attacked), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Empty board from the corner: only DR walks, seven squares.
    do_scan('0, 6'd0, 1'b0);
    check("empty_hit_valid", 32'(hit_valid), 32'd0);
    check("empty_attacked", 32'(attacked), 32'd0);
    check("empty_latency", 32'(last_lat), 32'd12);

    b = '0; b[36*4 +: 4] = 4'hD;
    do_scan(b, 6'd0, 1'b0);
    check("queen_hit_valid", 32'(hit_valid), 32'h8);
    check("queen_pos_dr", 32'(hit_pos[23:18]), 32'd36);
    check("queen_piece_dr", 32'(hit_piece[15:12]), 32'hD);
    check("queen_attacked", 32'(attacked), 32'd1);

    b = '0; b[9*4 +: 4] = 4'h3; b[18*4 +: 4] = 4'hB;
    do_scan(b, 6'd0, 1'b0);
    check("block_pos_dr", 32'(hit_pos[23:18]), 32'd9);
    check("block_attacked", 32'(attacked), 32'd0);

    b = '0; b[27*4 +: 4] = 4'hE;
    do_scan(b, 6'd36, 1'b0);
    check("king1_valid_ul", 32'(hit_valid[0]), 32'd1);
    check("king1_pos_ul", 32'(hit_pos[5:0]), 32'd27);
    check("king1_attacked", 32'(attacked), 32'd1);

    b = '0; b[18*4 +: 4] = 4'hE;
    do_scan(b, 6'd36, 1'b0);
    check("king2_pos_ul", 32'(hit_pos[5:0]), 32'd18);
    check("king2_attacked", 32'(attacked), 32'd0);

    // Enemy queens on every square a 6-bit wrap from square 7 could reach.
    b = '0;
    b[0*4 +: 4] = 4'hD; b[8*4 +: 4] = 4'hD; b[15*4 +: 4] = 4'hD;
    b[16*4 +: 4] = 4'hD; b[62*4 +: 4] = 4'hD;
    do_scan(b, 6'd7, 1'b0);
    check("edge7_hit_valid", 32'(hit_valid), 32'd0);
    check("edge7_attacked", 32'(attacked), 32'd0);
    check("edge7_latency", 32'(last_lat), 32'd12);

    // Abort mid-walk after a partial hit; a second start while busy is ignored.
    b = '0; b[19*4 +: 4] = 4'hD;
    start = 1'b1; bigBoard = b; currentPosition = 6'd28; my_colour = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    currentPosition = 6'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_partial_hv", 32'(hit_valid), 32'h1);
    check("abort_partial_pos", 32'(hit_pos[5:0]), 32'd19);
    check("abort_partial_atk", 32'(attacked), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_hit_valid", 32'(hit_valid), 32'd0);
    check("abort_hit_pos", 32'(hit_pos), 32'd0);
    check("abort_attacked", 32'(attacked), 32'd0);
    repeat (20) @(negedge clk);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Reset in the middle of a scan.
    start = 1'b1; bigBoard = rand_board(30); currentPosition = 6'd27; my_colour = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hit_valid", 32'(hit_valid), 32'd0);
    check("midrst_attacked", 32'(attacked), 32'd0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 40; i++)
      do_scan(rand_board(int'($urandom_range(40, 5))), 6'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
